// File: rtl/mem_lsu_if.sv
// Data-bus interface between the load/store unit (master) and data memory (slave).
interface mem_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req,
        output dbus_we,
        output dbus_addr,
        output dbus_sel,
        output dbus_wdata,
        input  dbus_ack,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_req,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_sel,
        input  dbus_wdata,
        output dbus_ack,
        output dbus_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: turns EX/MEM memory ops into single data-bus transfers,
// stalls the pipeline until the bus acknowledges, and forwards results to MEM/WB.
// Byte lanes are big-endian (address offset 0 is bits [31:24]).
// Optional build macro MEM_LSU_ALIGN_CHECK_EN: misaligned halfword/word accesses raise
// misalign_o instead of going to the bus.
module mem_lsu (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       mem_wd_i,
    input  logic             mem_wreg_i,
    input  logic [31:0]      mem_wdata_i,
    input  logic [3:0]       mem_op_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_sdata_i,
    mem_lsu_if.master        dbus,
    output logic [4:0]       wb_wd,
    output logic             wb_wreg,
    output logic [31:0]      wb_wdata,
    output logic             stall_req,
    output logic             misalign_o
);

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLw  = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q, load_q;
    logic [3:0]  sel_q;

    logic        is_load, is_store, is_signed, access, misalign, start;
    size_e       size;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d, load_d;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Decode the memory op into direction, access size and load extension.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SzWord;
        case (mem_op_i)
            OpLb:    begin is_load  = 1'b1; is_signed = 1'b1; size = SzByte; end
            OpLbu:   begin is_load  = 1'b1; size = SzByte; end
            OpLh:    begin is_load  = 1'b1; is_signed = 1'b1; size = SzHalf; end
            OpLhu:   begin is_load  = 1'b1; size = SzHalf; end
            OpLw:    begin is_load  = 1'b1; size = SzWord; end
            OpSb:    begin is_store = 1'b1; size = SzByte; end
            OpSh:    begin is_store = 1'b1; size = SzHalf; end
            OpSw:    begin is_store = 1'b1; size = SzWord; end
            default: ;  // 0 and 9-15 are no memory access
        endcase
    end

    assign access = is_load | is_store;

`ifdef MEM_LSU_ALIGN_CHECK_EN
    assign misalign = access &&
                      (((size == SzHalf) && mem_addr_i[0]) ||
                       ((size == SzWord) && (mem_addr_i[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign start = (state_q == StIdle) && access && !misalign;

    // Byte-lane select and replicated store data for the request being launched.
    always_comb begin
        sel_d   = 4'b1111;
        wdata_d = mem_sdata_i;
        case (size)
            SzByte: begin
                sel_d   = 4'b1000 >> mem_addr_i[1:0];
                wdata_d = {4{mem_sdata_i[7:0]}};
            end
            SzHalf: begin
                sel_d   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{mem_sdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed lane of the read data.
    always_comb begin
        case (mem_addr_i[1:0])
            2'b00:   byte_lane = dbus.dbus_rdata[31:24];
            2'b01:   byte_lane = dbus.dbus_rdata[23:16];
            2'b10:   byte_lane = dbus.dbus_rdata[15:8];
            default: byte_lane = dbus.dbus_rdata[7:0];
        endcase
        half_lane = mem_addr_i[1] ? dbus.dbus_rdata[15:0] : dbus.dbus_rdata[31:16];
        case (size)
            SzByte:  load_d = {{24{is_signed & byte_lane[7]}}, byte_lane};
            SzHalf:  load_d = {{16{is_signed & half_lane[15]}}, half_lane};
            default: load_d = dbus.dbus_rdata;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one transfer per op, DONE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (dbus.dbus_ack) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: pipeline stall and MEM/WB forwarding; everything quiet in reset.
    always_comb begin
        stall_req  = 1'b0;
        misalign_o = 1'b0;
        wb_wd      = mem_wd_i;
        wb_wreg    = mem_wreg_i;
        wb_wdata   = mem_wdata_i;
        if (!rst) begin
            wb_wd    = 5'd0;
            wb_wreg  = 1'b0;
            wb_wdata = 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (misalign) begin
                        misalign_o = 1'b1;
                        wb_wreg    = 1'b0;
                    end else if (access) begin
                        stall_req = 1'b1;
                        wb_wreg   = 1'b0;
                    end
                end
                StBusy: begin
                    stall_req = 1'b1;
                    wb_wreg   = 1'b0;
                end
                StDone: begin
                    if (we_q) begin
                        wb_wreg = 1'b0;
                    end else begin
                        wb_wdata = load_q;
                    end
                end
                default: wb_wreg = 1'b0;
            endcase
        end
    end

    // Bus request registers (held through BUSY) and load result capture on ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            load_q  <= 32'd0;
        end else if (start) begin
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {mem_addr_i[31:2], 2'b00};
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
        end else if ((state_q == StBusy) && dbus.dbus_ack) begin
            req_q  <= 1'b0;
            load_q <= load_d;
        end
    end

    assign dbus.dbus_req   = req_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_sel   = sel_q;
    assign dbus.dbus_wdata = wdata_q;

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have rst  input  1  asynchronous active-low reset (rst==0 resets).
REQ-003 SHALL have mem_wd_i  input  5  destination register from EX/MEM register.
REQ-004 SHALL have mem_wreg_i  input  1  write enable from EX/MEM register.
REQ-005 SHALL have mem_wdata_i  input  32  ALU result from EX/MEM register.
REQ-006 SHALL have mem_op_i  input  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-007 SHALL have mem_addr_i  input  32  byte address; mem_sdata_i  input  32  store data.
REQ-008 SHALL have dbus_req, dbus_we  output  1 each; dbus_addr  output  32; dbus_sel  output  4; dbus_wdata  output  32.
REQ-009 SHALL have dbus_ack  input  1; dbus_rdata  input  32.
REQ-010 SHALL have wb_wd  output  5; wb_wreg  output  1; wb_wdata  output  32 (to MEM/WB register).
REQ-011 SHALL have stall_req  output  1  hold upstream pipeline; misalign_o  output  1  alignment fault pulse.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE with NONE op: wb_wd/wb_wreg/wb_wdata = mem_wd_i/mem_wreg_i/mem_wdata_i combinationally; stall_req=0.
REQ-014 IDLE with aligned memory op: stall_req=1 combinationally; next edge registers dbus_addr={addr[31:2],2'b00}, dbus_sel, dbus_we (1 for SB/SH/SW), dbus_wdata, sets dbus_req=1, enters BUSY.
REQ-015 Byte lanes big-endian: addr[1:0]=00 -> sel 1000/bits[31:24] ... 11 -> sel 0001/bits[7:0]; halfword addr[1]=0 -> sel 1100, else 0011; word sel 1111.
REQ-016 Store data replicated: SB {4{sdata[7:0]}}, SH {2{sdata[15:0]}}, SW sdata.
REQ-017 BUSY: stall_req=1; dbus_req and all dbus_* outputs held stable until dbus_ack=1.
REQ-018 BUSY with dbus_ack=1: dbus_req cleared next edge, selected lane of dbus_rdata extracted (LB/LH sign-extended, LBU/LHU zero-extended, LW whole word) into load register, enter DONE.
REQ-019 DONE (exactly one cycle): stall_req=0; loads drive wb_wdata=load register, wb_wreg=mem_wreg_i, wb_wd=mem_wd_i; stores drive wb_wreg=0; next edge -> IDLE.
REQ-020 Latency: zero-wait ack gives IDLE, BUSY, DONE = 3 cycles; each extra wait cycle adds one BUSY cycle.
REQ-021 dbus_ack outside BUSY SHALL be ignored.
REQ-022 Upstream inputs are stable while stall_req=1; block does not re-sample op in BUSY/DONE.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_sel=0, dbus_wdata=0, load register=0.
REQ-024 While rst=0, wb_wd=0, wb_wreg=0, wb_wdata=0, stall_req=0, misalign_o=0.
REQ-025 Reset during BUSY SHALL abandon the transfer; a later ack is ignored.

Configuration
REQ-026 Macro MEM_LSU_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 in IDLE -> misalign_o=1, wb_wreg=0, stall_req=0, no bus request, stays IDLE.
REQ-027 Macro undefined: misalign_o tied 0; halfword ignores addr[0], word ignores addr[1:0]; access proceeds normally.

Verification
REQ-028 LW addr 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF -> req 1 cycle, sel 1111, DONE wb_wdata=0xDEADBEEF, stall_req high 2 cycles.
REQ-029 LB addr 0x103, rdata 0x000000F0 -> sel 0001, wb_wdata=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-030 SH addr 0x202, sdata 0x1234ABCD, ack after 3 wait cycles -> we=1, sel 0011, wdata 0xABCDABCD held 4 BUSY cycles, DONE wb_wreg=0.
REQ-031 rst=0 mid-BUSY then ack pulse -> dbus_req drops asynchronously, state IDLE, ack ignored, no DONE.
REQ-032 With MEM_LSU_ALIGN_CHECK_EN, LW addr 0x101 -> misalign_o=1, dbus_req stays 0, stall_req=0; without macro -> access to 0x100, sel 1111.
REQ-033 NONE op with mem_wd_i=5, mem_wreg_i=1, mem_wdata_i=0x55 -> same-cycle wb outputs 5/1/0x55, stall_req=0.
